stopwatch_bcd_counter: RTL and testbench
========================================

STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per 0.01 s count tick (100 MHz clock); legal range 2 and above.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start_stop  input  1  synchronized, debounced level; acts only on its rising edge.
REQ-005 SHALL have port lap  input  1  synchronized, debounced level; acts only on its rising edge.
REQ-006 SHALL have port clear  input  1  synchronized level; acts whenever high (no edge detect).
REQ-007 SHALL have ports D0, D1, D2, D3  output  4 each  displayed BCD digits, in that order: hundredths, tenths, seconds units, seconds tens; these feed the downstream digit-select mux.
REQ-008 SHALL have port running  output  1  high in RUN and LAP.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse when the count rolls over from 59.99 to 00.00.

Function
REQ-010 SHALL detect edges by registering start_stop and lap each cycle; a rising edge is the current input high with the registered value low.
REQ-011 SHALL implement states IDLE, RUN, PAUSE and LAP.
REQ-012 SHALL take these transitions in IDLE: start_stop edge goes to RUN; lap edge is ignored.
REQ-013 SHALL take these transitions in RUN: start_stop edge goes to PAUSE; lap edge goes to LAP.
REQ-014 SHALL take these transitions in LAP: lap edge goes to RUN; start_stop edge goes to PAUSE.
REQ-015 SHALL take these transitions in PAUSE: start_stop edge goes to RUN; lap edge goes to IDLE and zeroes the count and prescaler.
REQ-016 SHALL give clear the highest priority: clear high in any state goes to IDLE and zeroes the count, prescaler and snapshot in that same edge.
REQ-017 SHALL give start_stop priority over lap when both edges occur in the same cycle; that lap edge is discarded.
REQ-018 SHALL run the prescaler only in RUN and LAP: it counts 0 to TICK_DIV-1, then returns to 0 and issues a tick in that cycle.
REQ-019 SHALL hold the prescaler value in PAUSE, so that resuming continues the partial tick; it is zero in IDLE.
REQ-020 SHALL apply a tick to the live BCD count, making the new value visible on the clock edge that ends the tick cycle.
REQ-021 SHALL count in BCD: digit0 0-9 carries into digit1 0-9, which carries into digit2 0-9, which carries into digit3 0-5.
REQ-022 SHALL never produce a non-BCD value on any digit.
REQ-023 SHALL, on a tick at 59.99, set the count to 00.00, assert wrap for exactly that one registered cycle, and keep the state unchanged.
REQ-024 SHALL, on entering LAP, capture the live count into a snapshot on the same edge; D0-D3 then show the snapshot while the live count keeps advancing.
REQ-025 SHALL drive D0-D3 from the live count in every state other than LAP.
REQ-026 SHALL make D0-D3 show the live value from the next cycle onward when LAP is left.
REQ-027 SHALL register all outputs (no combinational path from any input to any output), with state and running updating on the same edge as the triggering input edge.
REQ-028 SHALL ignore a tick coincident with clear or with a lap edge in PAUSE; the zeroing wins.

Reset
REQ-029 SHALL, on any clock edge with rst_n low, force IDLE, prescaler 0, live count 00.00, snapshot 00.00, D0-D3 = 0, running 0, wrap 0, and both edge-detect registers 0.
REQ-030 SHALL, on reset mid-RUN or mid-LAP, discard all counting and produce no wrap pulse.
REQ-031 SHALL, after release, treat an input already high on the first cycle as a rising edge, because the edge registers are 0.

Verification (TICK_DIV=4)
REQ-032 SHALL cover: reset, then a start_stop pulse -> running=1 the next cycle; after 40 cycles D1,D0 = 1,0, with D0 passing 0 through 9 first.
REQ-033 SHALL cover: in RUN at 00.05 with the prescaler at 2, a start_stop pulse, 20 idle cycles, then a start_stop pulse -> the display holds 00.05 while paused; the next tick arrives 2 cycles after resume.
REQ-034 SHALL cover: a lap pulse at 00.12 in RUN -> D shows 00.12 while the live count advances; a second lap pulse after 40 cycles -> D shows 00.22.
REQ-035 SHALL cover: run for 24000 cycles from 00.00 -> wrap high for 1 cycle as D goes from 59.99 to 00.00; running stays 1.
REQ-036 SHALL cover: clear together with a start_stop edge in RUN -> IDLE, D = 00.00, running=0; a lap pulse in PAUSE -> IDLE with 00.00.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-LAP -> all outputs 0 on the next edge, and no wrap.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd_counter
//
// Four-digit BCD stopwatch (SS.hh, 00.00 .. 59.99) with start/stop, lap
// split and clear.  A prescaler divides clk down to a 0.01 s tick; the
// tick advances a BCD count whose value (or a frozen lap snapshot) is
// presented on the registered digit outputs.
//
// Parameters
//   TICK_DIV   clock cycles per 0.01 s tick (>= 2)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start_stop debounced level; its rising edge starts/stops/resumes
//   lap        debounced level; its rising edge enters/leaves lap view,
//              or resets the count to IDLE when paused
//   clear      level; while high forces IDLE and zeroes everything
//   D0..D3     displayed digits: hundredths, tenths, s units, s tens
//   running    high while counting (RUN or LAP)
//   wrap       one-cycle pulse when the count rolls 59.99 -> 00.00
// ---------------------------------------------------------------------------
module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic       running,
  output logic       wrap
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                ss_q_reg, lap_q_reg;
  logic                ss_edge, lap_edge;
  logic [PW-1:0]       presc_reg, presc_next;
  logic [3:0][3:0]     cnt_reg, cnt_next;
  logic [3:0][3:0]     snap_reg, snap_next;
  logic [3:0][3:0]     disp_reg, disp_next;
  logic                running_reg, running_next;
  logic                wrap_reg, wrap_next;

  logic                counting;
  logic                tick;
  logic [4:0]          carry;
  logic [3:0][3:0]     cnt_inc;

  // Rising edge: input high now, low on the previous cycle.  The edge
  // registers reset to 0, so a level already high after reset counts.
  assign ss_edge  = start_stop & ~ss_q_reg;
  assign lap_edge = lap & ~lap_q_reg;

  // The prescaler only runs while the current state is counting; in PAUSE
  // it holds so a resume finishes the partially elapsed tick.
  assign counting = (state_reg == RUN) || (state_reg == LAP);
  assign tick     = counting && (presc_reg == PRESC_MAX);

  // BCD ripple incrementer.  Each digit rolls over at its own limit and
  // passes a carry upward; carry out of the top digit is the 59.99 wrap.
  // Using >= on the limit folds any out-of-range value back to zero.
  assign carry[0] = tick;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 3) ? 4'd5 : 4'd9;
      logic at_lim;
      assign at_lim         = (cnt_reg[gi] >= LIM);
      assign carry[gi+1]    = carry[gi] & at_lim;
      assign cnt_inc[gi]    = !carry[gi] ? cnt_reg[gi]
                            : (at_lim ? 4'd0 : cnt_reg[gi] + 4'd1);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    cnt_next   = cnt_reg;
    snap_next  = snap_reg;
    wrap_next  = 1'b0;

    if (clear) begin
      // Clear overrides every edge and any coincident tick.
      state_next = IDLE;
      presc_next = '0;
      cnt_next   = '0;
      snap_next  = '0;
    end else begin
      if (counting) begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        cnt_next   = cnt_inc;
        wrap_next  = carry[4];
      end

      // start_stop is tested first everywhere, so a simultaneous lap
      // edge is simply dropped.
      unique case (state_reg)
        IDLE: begin
          if (ss_edge) state_next = RUN;
        end
        RUN: begin
          if (ss_edge) begin
            state_next = PAUSE;
          end else if (lap_edge) begin
            state_next = LAP;
            snap_next  = cnt_reg;
          end
        end
        LAP: begin
          if (ss_edge)       state_next = PAUSE;
          else if (lap_edge) state_next = RUN;
        end
        PAUSE: begin
          if (ss_edge) begin
            state_next = RUN;
          end else if (lap_edge) begin
            state_next = IDLE;
            presc_next = '0;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Outputs are computed from next-state values so they change on the
    // same edge as the state they describe.
    disp_next    = (state_next == LAP) ? snap_next : cnt_next;
    running_next = (state_next == RUN) || (state_next == LAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ss_q_reg    <= 1'b0;
      lap_q_reg   <= 1'b0;
      presc_reg   <= '0;
      cnt_reg     <= '0;
      snap_reg    <= '0;
      disp_reg    <= '0;
      running_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ss_q_reg    <= start_stop;
      lap_q_reg   <= lap;
      presc_reg   <= presc_next;
      cnt_reg     <= cnt_next;
      snap_reg    <= snap_next;
      disp_reg    <= disp_next;
      running_reg <= running_next;
      wrap_reg    <= wrap_next;
    end
  end

  assign D0      = disp_reg[0];
  assign D1      = disp_reg[1];
  assign D2      = disp_reg[2];
  assign D3      = disp_reg[3];
  assign running = running_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_bcd_counter
//
// Directed bench for stopwatch_bcd_counter with TICK_DIV = 4.  The stimulus
// process drives inputs just after a rising edge and queues the expected
// display/running/wrap values for specific edge numbers; an independent
// monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_bcd_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] D0, D1, D2, D3;
  logic       running;
  logic       wrap;

  stopwatch_bcd_counter #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .D0         (D0),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    logic [15:0] d;
    logic        run;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   wrap_cnt = 0;

  function automatic void push_exp(int at, string name, logic [15:0] d,
                                   logic run, logic wr);
    exp_t e;
    e.at = at; e.name = name; e.d = d; e.run = run; e.wr = wr;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation that is due at this edge.
  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_cnt++;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.at != cyc || {D3, D2, D1, D0} !== mon_e.d ||
          running !== mon_e.run || wrap !== mon_e.wr) begin
        errors++;
        $display("FAIL %s: cycle %0d got D=%h running=%b wrap=%b, expected cycle %0d D=%h running=%b wrap=%b",
                 mon_e.name, cyc, {D3, D2, D1, D0}, running, wrap,
                 mon_e.at, mon_e.d, mon_e.run, mon_e.wr);
      end else begin
        $display("ok   %-20s cycle %0d D=%h running=%b wrap=%b",
                 mon_e.name, cyc, {D3, D2, D1, D0}, running, wrap);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int n);
    while (cyc < n) step(1);
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s, p, r, t0, l, l2, s2, x, y, p2, q, z, w, k, v, lp, rs;

    rst_n = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step(2);
    push_exp(cyc, "reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Start from IDLE; D0 steps 0..9 every 4 cycles, then 00.10 at 40.
    start_stop = 1'b1; step(1); start_stop = 1'b0; e0 = cyc;
    push_exp(e0, "start_run", 16'h0000, 1'b1, 1'b0);
    push_exp(e0 + 3, "pre_first_tick", 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++)
      push_exp(e0 + 4 * i, "d0_step", 16'(i), 1'b1, 1'b0);
    push_exp(e0 + 40, "ten_hundredths", 16'h0010, 1'b1, 1'b0);
    wait_until(e0 + 40);

    clear = 1'b1; step(1); clear = 1'b0;
    push_exp(cyc, "clear_run", 16'h0000, 1'b0, 1'b0);

    // Pause at 00.05 with the prescaler held at 2, resume, partial tick.
    start_stop = 1'b1; step(1); start_stop = 1'b0; s = cyc;
    push_exp(s, "restart", 16'h0000, 1'b1, 1'b0);
    push_exp(s + 20, "at_05", 16'h0005, 1'b1, 1'b0);
    wait_until(s + 21);
    start_stop = 1'b1; step(1); start_stop = 1'b0; p = cyc;
    push_exp(p, "pause", 16'h0005, 1'b0, 1'b0);
    push_exp(p + 20, "paused_hold", 16'h0005, 1'b0, 1'b0);
    wait_until(p + 20);
    start_stop = 1'b1; step(1); start_stop = 1'b0; r = cyc;
    push_exp(r, "resume", 16'h0005, 1'b1, 1'b0);
    push_exp(r + 1, "resume_partial", 16'h0005, 1'b1, 1'b0);
    push_exp(r + 2, "resume_tick", 16'h0006, 1'b1, 1'b0);

    // Lap at 00.12: snapshot frozen while live count advances to 00.22.
    t0 = r + 26;
    push_exp(t0, "at_12", 16'h0012, 1'b1, 1'b0);
    wait_until(t0);
    lap = 1'b1; step(1); lap = 1'b0; l = cyc;
    push_exp(l, "lap_snap", 16'h0012, 1'b1, 1'b0);
    push_exp(l + 10, "lap_hold", 16'h0012, 1'b1, 1'b0);
    push_exp(l + 39, "lap_hold_end", 16'h0012, 1'b1, 1'b0);
    wait_until(l + 39);
    lap = 1'b1; step(1); lap = 1'b0; l2 = cyc;
    push_exp(l2, "lap_release", 16'h0022, 1'b1, 1'b0);

    // Full minute: carries through every digit and the 59.99 wrap.
    clear = 1'b1; step(1); clear = 1'b0;
    push_exp(cyc, "clear_lap", 16'h0000, 1'b0, 1'b0);
    start_stop = 1'b1; step(1); start_stop = 1'b0; s2 = cyc;
    push_exp(s2, "start_minute", 16'h0000, 1'b1, 1'b0);
    push_exp(s2 + 400, "one_second", 16'h0100, 1'b1, 1'b0);
    push_exp(s2 + 4000, "ten_seconds", 16'h1000, 1'b1, 1'b0);
    push_exp(s2 + 23996, "at_5999", 16'h5999, 1'b1, 1'b0);
    push_exp(s2 + 23999, "pre_wrap", 16'h5999, 1'b1, 1'b0);
    push_exp(s2 + 24000, "wrap", 16'h0000, 1'b1, 1'b1);
    push_exp(s2 + 24001, "post_wrap", 16'h0000, 1'b1, 1'b0);
    push_exp(s2 + 24004, "after_wrap_tick", 16'h0001, 1'b1, 1'b0);
    wait_until(s2 + 24004);

    // Clear beats a simultaneous start_stop edge in RUN.
    clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0; x = cyc;
    push_exp(x, "clear_beats_start", 16'h0000, 1'b0, 1'b0);
    push_exp(x + 4, "clear_stays_idle", 16'h0000, 1'b0, 1'b0);
    wait_until(x + 4);

    // Lap edge in PAUSE returns to IDLE and zeroes count and prescaler.
    start_stop = 1'b1; step(1); start_stop = 1'b0; y = cyc;
    push_exp(y, "start3", 16'h0000, 1'b1, 1'b0);
    push_exp(y + 12, "at_03", 16'h0003, 1'b1, 1'b0);
    wait_until(y + 12);
    start_stop = 1'b1; step(1); start_stop = 1'b0; p2 = cyc;
    push_exp(p2, "pause3", 16'h0003, 1'b0, 1'b0);
    wait_until(p2 + 1);
    lap = 1'b1; step(1); lap = 1'b0; q = cyc;
    push_exp(q, "lap_in_pause", 16'h0000, 1'b0, 1'b0);
    push_exp(q + 4, "idle_after_lap", 16'h0000, 1'b0, 1'b0);
    wait_until(q + 4);
    lap = 1'b1; step(1); lap = 1'b0;
    push_exp(cyc, "lap_ignored_idle", 16'h0000, 1'b0, 1'b0);
    start_stop = 1'b1; step(1); start_stop = 1'b0; z = cyc;
    push_exp(z, "restart_zero", 16'h0000, 1'b1, 1'b0);
    push_exp(z + 3, "presc_zeroed", 16'h0000, 1'b1, 1'b0);
    push_exp(z + 4, "first_tick", 16'h0001, 1'b1, 1'b0);
    wait_until(z + 4);

    // Simultaneous start_stop and lap edges in RUN: start_stop wins.
    start_stop = 1'b1; lap = 1'b1; step(1); start_stop = 1'b0; lap = 1'b0; w = cyc;
    push_exp(w, "ss_over_lap", 16'h0001, 1'b0, 1'b0);
    push_exp(w + 4, "paused_not_lap", 16'h0001, 1'b0, 1'b0);
    wait_until(w + 4);

    // Reset mid-LAP with start_stop already high at release.
    clear = 1'b1; step(1); clear = 1'b0; k = cyc;
    push_exp(k, "clear_before_lap", 16'h0000, 1'b0, 1'b0);
    start_stop = 1'b1; step(1); start_stop = 1'b0; v = cyc;
    push_exp(v, "start_f", 16'h0000, 1'b1, 1'b0);
    push_exp(v + 4, "f_tick", 16'h0001, 1'b1, 1'b0);
    wait_until(v + 5);
    lap = 1'b1; step(1); lap = 1'b0; lp = cyc;
    push_exp(lp, "lap_f", 16'h0001, 1'b1, 1'b0);
    push_exp(lp + 2, "lap_f_hold", 16'h0001, 1'b1, 1'b0);
    wait_until(lp + 2);
    rst_n = 1'b0; start_stop = 1'b1; step(1); rst_n = 1'b1; rs = cyc;
    push_exp(rs, "reset_mid_lap", 16'h0000, 1'b0, 1'b0);
    push_exp(rs + 1, "edge_after_reset", 16'h0000, 1'b1, 1'b0);
    wait_until(rs + 1);
    start_stop = 1'b0;
    push_exp(rs + 4, "post_reset_pretick", 16'h0000, 1'b1, 1'b0);
    push_exp(rs + 5, "post_reset_tick", 16'h0001, 1'b1, 1'b0);
    wait_until(rs + 5);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) step(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    checks++;
    if (wrap_cnt != 1) begin
      errors++;
      $display("FAIL wrap_pulse_count: got %0d pulses, expected 1", wrap_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
